// File: rtl/fp_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_add_pipe
//   Four-stage pipelined floating-point adder for IEEE-754-style words
//   {sign, exponent[EXP_W], fraction[MAN_W]}. Denormal inputs are read as
//   signed zero. Tiny results are flushed to zero. Rounding is to nearest,
//   ties to even.
//
//   Stages: S1 unpack / special detect / swap so |A| >= |B|
//           S2 align B with guard, round and sticky bits
//           S3 significand add or subtract
//           S4 normalize, round, pack (this is the output register)
//
//   Ports
//     clk        single clock, rising edge
//     reset_n    asynchronous active-low reset
//     in_valid   operand pair a/b presented
//     in_ready   pair accepted this cycle (global advance enable)
//     a, b       operands
//     out_valid  x/flags hold a result
//     out_ready  consumer takes the result this cycle
//     x          a + b
//     flags      {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] x,
   output logic [3:0]           flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 4;          // hidden bit + fraction + G/R/S
   localparam int LZ_W = $clog2(SW + 1);
   localparam int EE_W = EXP_W + 2;          // room for exponent carry and borrow

   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_INF  = 2'd1,
      SP_NAN  = 2'd2
   } special_e;

   // ---------------------------------------------------------------------------
   // Global advance enable: every stage moves together or holds together.
   // ---------------------------------------------------------------------------
   logic en;
   logic out_valid_q;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   // ---------------------------------------------------------------------------
   // S1: unpack, special detection, magnitude swap
   // ---------------------------------------------------------------------------
   logic                   a_sgn, b_sgn;
   logic [EXP_W-1:0]       a_exp, b_exp;
   logic [MAN_W-1:0]       a_frc, b_frc;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
   logic [MAN_W:0]         a_man, b_man;
   logic                   swap;

   special_e               s1_sp_d;
   logic                   s1_sp_sign_d, s1_sign_d, s1_sub_d;
   logic [EXP_W-1:0]       s1_exp_d, s1_diff_d;
   logic [MAN_W:0]         s1_ma_d, s1_mb_d;

   always_comb begin : s1_unpack
      a_sgn = a[W-1];
      a_exp = a[W-2:MAN_W];
      a_frc = a[MAN_W-1:0];
      b_sgn = b[W-1];
      b_exp = b[W-2:MAN_W];
      b_frc = b[MAN_W-1:0];

      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_inf  = (a_exp == EXP_ONES) && (a_frc == '0);
      b_inf  = (b_exp == EXP_ONES) && (b_frc == '0);
      a_nan  = (a_exp == EXP_ONES) && (a_frc != '0);
      b_nan  = (b_exp == EXP_ONES) && (b_frc != '0);

      s1_sp_d      = SP_NONE;
      s1_sp_sign_d = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) begin
         s1_sp_d = SP_NAN;
      end else if (a_inf || b_inf) begin
         s1_sp_d      = SP_INF;
         s1_sp_sign_d = a_inf ? a_sgn : b_sgn;
      end

      // Denormals are flushed, so a zero exponent means a zero magnitude.
      a_mag = a_zero ? '0 : {a_exp, a_frc};
      b_mag = b_zero ? '0 : {b_exp, b_frc};
      a_man = a_zero ? '0 : {1'b1, a_frc};
      b_man = b_zero ? '0 : {1'b1, b_frc};
      swap  = (b_mag > a_mag);

      if (swap) begin
         s1_sign_d = b_sgn;
         s1_exp_d  = b_exp;
         s1_ma_d   = b_man;
         s1_mb_d   = a_man;
         s1_diff_d = b_exp - a_exp;
      end else begin
         s1_sign_d = a_sgn;
         s1_exp_d  = a_exp;
         s1_ma_d   = a_man;
         s1_mb_d   = b_man;
         s1_diff_d = a_exp - b_exp;
      end
      s1_sub_d = a_sgn ^ b_sgn;
   end

   logic             s1_valid_q;
   special_e         s1_sp_q;
   logic             s1_sp_sign_q, s1_sign_q, s1_sub_q;
   logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
   logic [MAN_W:0]   s1_ma_q, s1_mb_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q   <= 1'b0;
         s1_sp_q      <= SP_NONE;
         s1_sp_sign_q <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_sub_q     <= 1'b0;
         s1_exp_q     <= '0;
         s1_diff_q    <= '0;
         s1_ma_q      <= '0;
         s1_mb_q      <= '0;
      end else if (en) begin
         s1_valid_q   <= in_valid;
         s1_sp_q      <= s1_sp_d;
         s1_sp_sign_q <= s1_sp_sign_d;
         s1_sign_q    <= s1_sign_d;
         s1_sub_q     <= s1_sub_d;
         s1_exp_q     <= s1_exp_d;
         s1_diff_q    <= s1_diff_d;
         s1_ma_q      <= s1_ma_d;
         s1_mb_q      <= s1_mb_d;
      end
   end

   // ---------------------------------------------------------------------------
   // S2: align the smaller significand. Bits shifted past the sticky position
   // are OR-ed into it; very large shifts leave only the sticky bit.
   // ---------------------------------------------------------------------------
   logic [2*SW-1:0] align_wide;
   logic [SW-1:0]   s2_ma_d, s2_mb_d;

   always_comb begin : s2_align
      align_wide = {s1_mb_q, 3'b000, SW'(0)} >> s1_diff_q;
      if (32'(s1_diff_q) >= 32'(MAN_W + 3)) begin
         s2_mb_d = {{(SW-1){1'b0}}, |s1_mb_q};
      end else begin
         s2_mb_d = {align_wide[2*SW-1:SW+1], align_wide[SW] | (|align_wide[SW-1:0])};
      end
      s2_ma_d = {s1_ma_q, 3'b000};
   end

   logic             s2_valid_q;
   special_e         s2_sp_q;
   logic             s2_sp_sign_q, s2_sign_q, s2_sub_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic [SW-1:0]    s2_ma_q, s2_mb_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q   <= 1'b0;
         s2_sp_q      <= SP_NONE;
         s2_sp_sign_q <= 1'b0;
         s2_sign_q    <= 1'b0;
         s2_sub_q     <= 1'b0;
         s2_exp_q     <= '0;
         s2_ma_q      <= '0;
         s2_mb_q      <= '0;
      end else if (en) begin
         s2_valid_q   <= s1_valid_q;
         s2_sp_q      <= s1_sp_q;
         s2_sp_sign_q <= s1_sp_sign_q;
         s2_sign_q    <= s1_sign_q;
         s2_sub_q     <= s1_sub_q;
         s2_exp_q     <= s1_exp_q;
         s2_ma_q      <= s2_ma_d;
         s2_mb_q      <= s2_mb_d;
      end
   end

   // ---------------------------------------------------------------------------
   // S3: add or subtract. |A| >= |B| after the swap, so the difference never
   // goes negative.
   // ---------------------------------------------------------------------------
   logic [SW:0] s3_sum_d;

   always_comb begin : s3_addsub
      if (s2_sub_q) begin
         s3_sum_d = {1'b0, s2_ma_q} - {1'b0, s2_mb_q};
      end else begin
         s3_sum_d = {1'b0, s2_ma_q} + {1'b0, s2_mb_q};
      end
   end

   logic             s3_valid_q;
   special_e         s3_sp_q;
   logic             s3_sp_sign_q, s3_sign_q, s3_sub_q;
   logic [EXP_W-1:0] s3_exp_q;
   logic [SW:0]      s3_sum_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s3_valid_q   <= 1'b0;
         s3_sp_q      <= SP_NONE;
         s3_sp_sign_q <= 1'b0;
         s3_sign_q    <= 1'b0;
         s3_sub_q     <= 1'b0;
         s3_exp_q     <= '0;
         s3_sum_q     <= '0;
      end else if (en) begin
         s3_valid_q   <= s2_valid_q;
         s3_sp_q      <= s2_sp_q;
         s3_sp_sign_q <= s2_sp_sign_q;
         s3_sign_q    <= s2_sign_q;
         s3_sub_q     <= s2_sub_q;
         s3_exp_q     <= s2_exp_q;
         s3_sum_q     <= s3_sum_d;
      end
   end

   // ---------------------------------------------------------------------------
   // S4: normalize, round to nearest even, pack
   // ---------------------------------------------------------------------------
   function automatic logic [LZ_W-1:0] lzc(input logic [SW-1:0] v);
      logic [LZ_W-1:0] n;
      logic            found;
      n     = LZ_W'(SW);
      found = 1'b0;
      for (int unsigned i = 0; i < SW; i++) begin
         if (!found && v[SW-1-i]) begin
            found = 1'b1;
            n     = LZ_W'(i);
         end
      end
      return n;
   endfunction

   logic [LZ_W-1:0]  lz;
   logic [SW-1:0]    norm;
   logic [EE_W-1:0]  e_norm, e_rnd;
   logic             rnd_g, rnd_r, rnd_s, rnd_up, inexact;
   logic [MAN_W+1:0] man_rnd;
   logic [MAN_W-1:0] frc_rnd;
   logic [W-1:0]     x_d;
   logic [3:0]       flags_d;

   always_comb begin : s4_norm_round
      lz = lzc(s3_sum_q[SW-1:0]);
      if (s3_sum_q[SW]) begin
         // Carry out of the add: shift right once, keep the lost bit in sticky.
         norm   = {s3_sum_q[SW:2], s3_sum_q[1] | s3_sum_q[0]};
         e_norm = EE_W'(s3_exp_q) + EE_W'(1);
      end else begin
         norm   = s3_sum_q[SW-1:0] << lz;
         e_norm = EE_W'(s3_exp_q) - EE_W'(lz);
      end

      rnd_g   = norm[2];
      rnd_r   = norm[1];
      rnd_s   = norm[0];
      rnd_up  = rnd_g && (rnd_r || rnd_s || norm[3]);
      inexact = rnd_g || rnd_r || rnd_s;
      man_rnd = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_up);
      // Rounding carry (significand 10.00..0) bumps the exponent; fraction is 0.
      e_rnd   = e_norm + EE_W'(man_rnd[MAN_W+1]);
      frc_rnd = man_rnd[MAN_W+1] ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];

      x_d     = '0;
      flags_d = '0;
      if (s3_sp_q == SP_NAN) begin
         x_d     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
         flags_d = 4'b1000;
      end else if (s3_sp_q == SP_INF) begin
         x_d = {s3_sp_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (s3_sum_q == '0) begin
         // Exact zero: -0 only survives when both operands were -0.
         x_d = {!s3_sub_q && s3_sign_q, {(W-1){1'b0}}};
      end else if (e_norm[EE_W-1] || (e_norm == '0)) begin
         x_d     = {s3_sign_q, {(W-1){1'b0}}};
         flags_d = 4'b0011;
      end else if (e_rnd >= EE_W'(EXP_ONES)) begin
         x_d     = {s3_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         flags_d = 4'b0101;
      end else begin
         x_d     = {s3_sign_q, e_rnd[EXP_W-1:0], frc_rnd};
         flags_d = {3'b000, inexact};
      end
   end

   logic [W-1:0] x_q;
   logic [3:0]   flags_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         flags_q     <= '0;
      end else if (en) begin
         out_valid_q <= s3_valid_q;
         x_q         <= x_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign x         = x_q;
   assign flags     = flags_q;

endmodule
